// File: rtl/timer_tick_sequencer.sv
// Avalon-MM initiator that programs the 16-bit interval timer and counts/acks its timeout irqs.
// Latency: accept to first timer write 1 cycle, to START write 5 cycles (9 with TIMER_READBACK_EN).
// Backpressure: cmd_ready only in IDLE; the timer has no waitrequest, so every access is single-cycle.
// Optional feature macro: TIMER_READBACK_EN (reads back the period registers before starting).
module timer_tick_sequencer #(
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_period,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [2:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [15:0]      writedata,
  input  logic [15:0]      readdata,
  input  logic             irq,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] ticks_left
);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_PER_L, S_PER_H,
    S_RB_L, S_RB_LC, S_RB_H, S_RB_HC,
    S_CLR, S_START, S_WAIT, S_ACK, S_HOLD, S_FIN, S_DONE
  } state_e;

  // Last WAIT cycle index before the watchdog fires.
  localparam logic [31:0] WDOG_LAST = (WDOG_CYCLES > 0) ? 32'(WDOG_CYCLES - 1) : 32'd0;
  localparam logic        WDOG_EN   = (WDOG_CYCLES > 0);

  state_e             state_q, state_d;
  logic [31:0]        period_q, period_d;
  logic [CNT_W-1:0]   ticks_q, ticks_d;
  logic               error_q, error_d;
  logic               hold_q, hold_d;
  logic [31:0]        wdog_q, wdog_d;
  logic               abort_go;

`ifndef TIMER_READBACK_EN
  // Without readback the timer's read port is never consulted.
  logic unused_readdata;
  assign unused_readdata = ^readdata;
`endif

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign ticks_left = ticks_q;

  // Abort only cuts short an active command that is not already shutting the timer down.
  assign abort_go = abort && (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_DONE);

  // Next-state, datapath updates and bus drive decoded from the current state.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    ticks_d    = ticks_q;
    error_d    = error_q;
    hold_d     = 1'b0;
    wdog_d     = 32'd0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          period_d = cmd_period;
          ticks_d  = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
          error_d  = 1'b0;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        address = 3'd1; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0008;
        state_d = S_PER_L;
      end
      S_PER_L: begin
        address = 3'd2; chipselect = 1'b1; write_n = 1'b0; writedata = period_q[15:0];
        state_d = S_PER_H;
      end
      S_PER_H: begin
        address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = period_q[31:16];
`ifdef TIMER_READBACK_EN
        state_d = S_RB_L;
`else
        state_d = S_CLR;
`endif
      end
`ifdef TIMER_READBACK_EN
      S_RB_L: begin
        address = 3'd2; chipselect = 1'b1;
        state_d = S_RB_LC;
      end
      S_RB_LC: begin
        // readdata is registered in the timer, so it reflects the previous cycle's address.
        if (readdata != period_q[15:0]) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_RB_H;
        end
      end
      S_RB_H: begin
        address = 3'd3; chipselect = 1'b1;
        state_d = S_RB_HC;
      end
      S_RB_HC: begin
        if (readdata != period_q[31:16]) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_CLR;
        end
      end
`endif
      S_CLR: begin
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        address = 3'd1; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0007;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 32'd1;
        if (irq) begin
          ticks_d = ticks_q - CNT_W'(1);
          state_d = S_ACK;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_ACK: begin
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0;
        state_d = (ticks_q == '0) ? S_FIN : S_HOLD;
      end
      S_HOLD: begin
        // Two idle cycles let the timer drop irq after the ack before WAIT samples it.
        hold_d = 1'b1;
        if (hold_q) state_d = S_WAIT;
      end
      S_FIN: begin
        address = 3'd1; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0008;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats irq and watchdog: no decrement, no error, straight to stopping the timer.
    if (abort_go) begin
      state_d = S_FIN;
      ticks_d = ticks_q;
      error_d = error_q;
    end
  end

  // State and datapath registers; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= 32'd0;
      ticks_q  <= '0;
      error_q  <= 1'b0;
      hold_q   <= 1'b0;
      wdog_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      ticks_q  <= ticks_d;
      error_q  <= error_d;
      hold_q   <= hold_d;
      wdog_q   <= wdog_d;
    end
  end

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Directed bench for timer_tick_sequencer: bus write log, done counter, simple timer read model.
// Inputs driven on the falling edge; DUT outputs sampled on the falling edge.
// Watchdog instance parameter is 100 cycles.
module tb_timer_tick_sequencer;

  localparam int WDOG = 100;
`ifdef TIMER_READBACK_EN
  localparam int START_OFS = 9;
`else
  localparam int START_OFS = 5;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_period = 32'd0;
  logic [15:0] cmd_count = 16'd0;
  logic        abort = 1'b0;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata = 16'd0;
  logic        irq = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] ticks_left;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  logic [18:0] wr_q[$];
  int          wr_edge[$];
  logic [15:0] model_l = 16'd0;
  logic [15:0] model_h = 16'd0;

  timer_tick_sequencer #(.CNT_W(16), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_count(cmd_count), .abort(abort),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .busy(busy), .done(done), .error(error), .ticks_left(ticks_left)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer read port model: registered, one cycle after the address.
  always @(posedge clk)
    readdata <= (address == 3'd2) ? model_l : (address == 3'd3) ? model_h : 16'd0;

  // Log each write as {addr,data} with the clock edge that captures it.
  always @(negedge clk) begin
    if (chipselect && !write_n) begin
      wr_q.push_back({address, writedata});
      wr_edge.push_back(cyc + 1);
    end
    if (chipselect && write_n) rd_cnt++;
    if (done) done_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_cmd(input logic [31:0] per, input logic [15:0] cnt,
                           input logic [15:0] ml, input logic [15:0] mh, output int acc);
    @(negedge clk);
    wr_q.delete(); wr_edge.delete(); done_cnt = 0;
    model_l = ml; model_h = mh;
    cmd_period = per; cmd_count = cnt; cmd_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_irq();
    @(negedge clk); irq = 1'b1;
    @(negedge clk); irq = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    idle(2);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (chipselect !== 1'b0) begin failures++; $display("FAIL rst_chipselect got %b want 0", chipselect); end
    checks++; if (write_n !== 1'b1) begin failures++; $display("FAIL rst_write_n got %b want 1", write_n); end
    checks++; if ({address, writedata} !== 19'h0) begin failures++; $display("FAIL rst_bus got %h want 0", {address, writedata}); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL rst_status got %b want 000", {busy, done, error}); end
    checks++; if (ticks_left !== 16'd0) begin failures++; $display("FAIL rst_ticks got %0d want 0", ticks_left); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int acc; bit ok;
    logic [18:0] exp[8] = '{19'h10008, 19'h286A0, 19'h30001, 19'h00000,
                            19'h10007, 19'h00000, 19'h00000, 19'h10008};
    issue_cmd(32'h000186A0, 16'd2, 16'h86A0, 16'h0001, acc);
    checks++; if (ticks_left !== 16'd2) begin failures++; $display("FAIL basic_ticks0 got %0d want 2", ticks_left); end
    idle(START_OFS + 3);
    pulse_irq();
    idle(6);
    checks++; if (ticks_left !== 16'd1) begin failures++; $display("FAIL basic_ticks1 got %0d want 1", ticks_left); end
    pulse_irq();
    wait_idle(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got busy want idle"); end
    checks++; if (ticks_left !== 16'd0) begin failures++; $display("FAIL basic_ticks2 got %0d want 0", ticks_left); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL basic_error got %b want 0", error); end
    checks++; if (wr_q.size() != 8) begin failures++; $display("FAIL basic_nwr got %0d want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp[i]) begin
        failures++; $display("FAIL basic_wr%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 19'h7FFFF, exp[i]);
      end
    end
    if (wr_q.size() >= 5) begin
      checks++; if (wr_edge[0] != acc + 1) begin failures++; $display("FAIL first_wr_lat got %0d want %0d", wr_edge[0] - acc, 1); end
      checks++; if (wr_edge[4] != acc + START_OFS) begin failures++; $display("FAIL start_lat got %0d want %0d", wr_edge[4] - acc, START_OFS); end
    end
  endtask

  task automatic test_count_zero();
    int acc; bit ok;
    issue_cmd(32'h00001000, 16'd0, 16'h1000, 16'h0000, acc);
    checks++; if (ticks_left !== 16'd1) begin failures++; $display("FAIL cz_ticks got %0d want 1", ticks_left); end
    idle(START_OFS + 3);
    pulse_irq();
    wait_idle(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cz_timeout got busy want idle"); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL cz_done got %0d want 1", done_cnt); end
    checks++; if (wr_q.size() != 7) begin failures++; $display("FAIL cz_nwr got %0d want 7", wr_q.size()); end
    else begin
      checks++; if (wr_q[5] !== 19'h00000 || wr_q[6] !== 19'h10008) begin
        failures++; $display("FAIL cz_tail got %h %h want 00000 10008", wr_q[5], wr_q[6]);
      end
    end
  endtask

  task automatic test_abort();
    int acc, n; bit ok;
    issue_cmd(32'h000186A0, 16'd3, 16'h86A0, 16'h0001, acc);
    idle(START_OFS + 3);
    @(negedge clk); abort = 1'b1; n = cyc;
    @(negedge clk); abort = 1'b0;
    wait_idle(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_timeout got busy want idle"); end
    checks++; if (wr_q.size() != 6) begin failures++; $display("FAIL abort_nwr got %0d want 6", wr_q.size()); end
    else begin
      checks++; if (wr_q[5] !== 19'h10008) begin failures++; $display("FAIL abort_fin got %h want 10008", wr_q[5]); end
      checks++; if (wr_edge[5] != n + 2) begin failures++; $display("FAIL abort_lat got %0d want %0d", wr_edge[5], n + 2); end
    end
    checks++; if (ticks_left !== 16'd3) begin failures++; $display("FAIL abort_ticks got %0d want 3", ticks_left); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL abort_error got %b want 0", error); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL abort_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort_irq();
    int acc; bit ok;
    issue_cmd(32'h00000400, 16'd2, 16'h0400, 16'h0000, acc);
    idle(START_OFS + 3);
    pulse_irq();
    idle(6);
    @(negedge clk); abort = 1'b1; irq = 1'b1;
    @(negedge clk); abort = 1'b0; irq = 1'b0;
    wait_idle(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abirq_timeout got busy want idle"); end
    checks++; if (ticks_left !== 16'd1) begin failures++; $display("FAIL abirq_ticks got %0d want 1", ticks_left); end
    checks++; if (wr_q.size() != 7) begin failures++; $display("FAIL abirq_nwr got %0d want 7", wr_q.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL abirq_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_watchdog();
    int acc; bit ok;
    issue_cmd(32'h000186A0, 16'd1, 16'h86A0, 16'h0001, acc);
    wait_idle(WDOG + 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wdog_timeout got busy want idle"); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL wdog_error got %b want 1", error); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL wdog_done got %0d want 1", done_cnt); end
    checks++; if (wr_q.size() != 6) begin failures++; $display("FAIL wdog_nwr got %0d want 6", wr_q.size()); end
    else begin
      checks++; if (wr_q[5] !== 19'h10008) begin failures++; $display("FAIL wdog_fin got %h want 10008", wr_q[5]); end
      checks++; if (wr_edge[5] != acc + START_OFS + WDOG + 1) begin
        failures++; $display("FAIL wdog_lat got %0d want %0d", wr_edge[5] - acc, START_OFS + WDOG + 1);
      end
    end
    idle(3);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL wdog_sticky got %b want 1", error); end
    // Next accepted command clears the sticky error.
    issue_cmd(32'h00000200, 16'd1, 16'h0200, 16'h0000, acc);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL wdog_clear got %b want 0", error); end
    idle(START_OFS + 3);
    pulse_irq();
    wait_idle(30, ok);
    checks++; if (!ok || error !== 1'b0) begin failures++; $display("FAIL wdog_next got ok=%b err=%b want ok=1 err=0", ok, error); end
  endtask

  task automatic test_reset_mid();
    int acc;
    issue_cmd(32'h000186A0, 16'd2, 16'h86A0, 16'h0001, acc);
    idle(2);
    checks++; if ({address, write_n} !== 4'b0110) begin failures++; $display("FAIL mid_perh got %b want 0110", {address, write_n}); end
    reset = 1'b1;
    #1;
    checks++; if ({cmd_ready, chipselect, write_n} !== 3'b101) begin failures++; $display("FAIL mid_rst_ctl got %b want 101", {cmd_ready, chipselect, write_n}); end
    checks++; if ({address, writedata, busy, done, error} !== 22'h0) begin failures++; $display("FAIL mid_rst_out got %h want 0", {address, writedata, busy, done, error}); end
    checks++; if (ticks_left !== 16'd0) begin failures++; $display("FAIL mid_rst_ticks got %0d want 0", ticks_left); end
    @(negedge clk); reset = 1'b0;
    wr_q.delete(); wr_edge.delete();
    idle(4);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_release got rdy=%b busy=%b want 1 0", cmd_ready, busy); end
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL mid_nwr got %0d want 0", wr_q.size()); end
  endtask

`ifdef TIMER_READBACK_EN
  task automatic test_readback();
    int acc; bit ok;
    issue_cmd(32'h000186A0, 16'd1, 16'h86A1, 16'h0001, acc);
    wait_idle(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rb_timeout got busy want idle"); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL rb_error got %b want 1", error); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rb_done got %0d want 1", done_cnt); end
    checks++; if (wr_q.size() != 4) begin failures++; $display("FAIL rb_nwr got %0d want 4", wr_q.size()); end
    else begin
      checks++; if (wr_q[3] !== 19'h10008) begin failures++; $display("FAIL rb_fin got %h want 10008", wr_q[3]); end
    end
  endtask
`else
  task automatic test_no_reads();
    checks++; if (rd_cnt != 0) begin failures++; $display("FAIL no_reads got %0d want 0", rd_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_count_zero();
    test_abort();
    test_abort_irq();
    test_watchdog();
    test_reset_mid();
`ifdef TIMER_READBACK_EN
    test_readback();
`else
    test_no_reads();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
